operand_fetch: RTL and testbench

// - Read-side companion to the register file: issues rs1/rs2 read addresses, and captures operands into a registered output stage.
// - Bypasses same-cycle write-back data to the captured operands.
// - Tracks in-flight destination registers with a scoreboard and stalls on RAW/WAW hazards.
// - Sits between decode (upstream valid/ready) and execute (downstream valid/ready).

---
 rtl/regfile_pkg.sv | 12 +
 rtl/reg_scoreboard.sv | 52 +++++
 rtl/operand_fetch.sv | 113 +++++++++++
 tb/tb_operand_fetch.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: constants shared by the register file, write-back stage and
// operand fetch.
//   XLEN     - operand / write-back data width
//   AW       - register address width (2**AW architectural registers)
//   NREG     - number of architectural registers
//   REG_ZERO - address of the hard-wired zero register x0
package regfile_pkg;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREG = 1 << AW;
  localparam logic [AW-1:0] REG_ZERO = '0;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: one pending bit per architectural register, marking a
// destination that has been issued but not yet written back.
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   set_en / set_idx     - mark a register pending (issue of a writer)
//   clr_a_en / clr_a_idx - clear a pending bit (write-back)
//   clr_b_en / clr_b_idx - clear a pending bit (flushed instruction)
//   rdN_idx / rdN_pend   - three combinational read ports (rs1, rs2, rd)
// A set and a clear of the same index in one cycle leave the bit set: the
// new writer is still outstanding even though an older one just retired.
// Bit 0 (x0) never becomes pending.
module reg_scoreboard
  import regfile_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic          clr_a_en,
  input  logic [AW-1:0] clr_a_idx,
  input  logic          clr_b_en,
  input  logic [AW-1:0] clr_b_idx,
  input  logic [AW-1:0] rd1_idx,
  input  logic [AW-1:0] rd2_idx,
  input  logic [AW-1:0] rd3_idx,
  output logic          rd1_pend,
  output logic          rd2_pend,
  output logic          rd3_pend
);

  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;

  // Clears first, then set, so a same-index set overrides either clear.
  always_comb begin
    pend_d = pend_q;
    if (clr_a_en) pend_d[clr_a_idx] = 1'b0;
    if (clr_b_en) pend_d[clr_b_idx] = 1'b0;
    if (set_en)   pend_d[set_idx]   = 1'b1;
    pend_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  assign rd1_pend = pend_q[rd1_idx];
  assign rd2_pend = pend_q[rd2_idx];
  assign rd3_pend = pend_q[rd3_idx];

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: reads rs1/rs2 from the register file, bypasses same-cycle
// write-back data, stalls on RAW/WAW hazards against in-flight destinations
// and presents operands to execute from a one-entry registered stage.
// Ports:
//   clk, rst_n                       - clock, synchronous active-low reset
//   in_valid/in_ready, in_rs1/2,
//   in_rs1/2_used, in_rd, in_rd_wen  - decode side
//   rf_raddr1/2, rf_rdata1/2         - asynchronous register file read
//   wb_valid, wb_rd, wb_data         - write-back (rf writes at the same edge)
//   flush                            - kill the instruction in the output stage
//   out_valid/out_ready, out_a/b,
//   out_rd, out_rd_wen               - execute side
// Handshake: a transfer happens on a rising edge where valid && ready are both
// 1. in_ready never depends on in_valid. out_valid, once raised, holds with
// all out_* stable until out_ready or flush; flush drops it without transfer.
module operand_fetch
  import regfile_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_rs1,
  input  logic [AW-1:0]   in_rs2,
  input  logic            in_rs1_used,
  input  logic            in_rs2_used,
  input  logic [AW-1:0]   in_rd,
  input  logic            in_rd_wen,
  output logic [AW-1:0]   rf_raddr1,
  output logic [AW-1:0]   rf_raddr2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [AW-1:0]   out_rd,
  output logic            out_rd_wen
);

  logic            byp1, byp2, wb_hits_rd;
  logic            pend_rs1, pend_rs2, pend_rd;
  logic            hazard, accept;
  logic [XLEN-1:0] op_a, op_b;

  assign rf_raddr1 = in_rs1;
  assign rf_raddr2 = in_rs2;

  // The register file commits wb_data at the same edge we capture, so its
  // read port still shows the old value: forward from write-back instead.
  assign byp1       = wb_valid && (wb_rd == in_rs1) && (in_rs1 != REG_ZERO);
  assign byp2       = wb_valid && (wb_rd == in_rs2) && (in_rs2 != REG_ZERO);
  assign wb_hits_rd = wb_valid && (wb_rd == in_rd);

  always_comb begin
    op_a = rf_rdata1;
    if (in_rs1 == REG_ZERO) op_a = '0;
    else if (byp1)          op_a = wb_data;
    op_b = rf_rdata2;
    if (in_rs2 == REG_ZERO) op_b = '0;
    else if (byp2)          op_b = wb_data;
  end

  reg_scoreboard u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (accept && in_rd_wen && (in_rd != REG_ZERO)),
    .set_idx   (in_rd),
    .clr_a_en  (wb_valid),
    .clr_a_idx (wb_rd),
    .clr_b_en  (flush && out_valid && out_rd_wen),
    .clr_b_idx (out_rd),
    .rd1_idx   (in_rs1),
    .rd2_idx   (in_rs2),
    .rd3_idx   (in_rd),
    .rd1_pend  (pend_rs1),
    .rd2_pend  (pend_rs2),
    .rd3_pend  (pend_rd)
  );

  // A pending source is fine if it is being written back this very cycle.
  // A pending destination (WAW) is fine likewise: the old writer retires
  // now and the new one re-marks the bit.
  assign hazard = (in_rs1_used && pend_rs1 && !byp1)
               || (in_rs2_used && pend_rs2 && !byp2)
               || (in_rd_wen && (in_rd != REG_ZERO) && pend_rd && !wb_hits_rd);

  assign in_ready = rst_n && !hazard && !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_a      <= '0;
      out_b      <= '0;
      out_rd     <= '0;
      out_rd_wen <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_a      <= op_a;
      out_b      <= op_b;
      out_rd     <= in_rd;
      out_rd_wen <= in_rd_wen;
    end else if (flush || out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Testbench for operand_fetch: directed table, directed hazard sequences and
// randomized traffic checked against a cycle-level behavioural model.
module tb_operand_fetch;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int EW   = 1 + AW + 2 * XLEN;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, in_ready;
  logic [AW-1:0]   in_rs1, in_rs2, in_rd;
  logic            in_rs1_used, in_rs2_used, in_rd_wen;
  logic [AW-1:0]   rf_raddr1, rf_raddr2;
  logic [XLEN-1:0] rf_rdata1, rf_rdata2;
  logic            wb_valid;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            flush;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] out_a, out_b;
  logic [AW-1:0]   out_rd;
  logic            out_rd_wen;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model state
  bit              m_pend [32];
  bit              m_ov;
  logic [EW-1:0]   exp_q [$];

  operand_fetch dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_used(in_rs1_used),
    .in_rs2_used(in_rs2_used), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a),
    .out_b(out_b), .out_rd(out_rd), .out_rd_wen(out_rd_wen)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic idle_inputs();
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rs1_used = 0; in_rs2_used = 0;
    in_rd = 0; in_rd_wen = 0; rf_rdata1 = 0; rf_rdata2 = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0; flush = 0;
  endtask

  task automatic drive(input logic [AW-1:0] rs1, input logic u1,
                       input logic [AW-1:0] rs2, input logic u2,
                       input logic [AW-1:0] rd, input logic wen,
                       input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2);
    in_valid = 1; in_rs1 = rs1; in_rs1_used = u1; in_rs2 = rs2;
    in_rs2_used = u2; in_rd = rd; in_rd_wen = wen;
    rf_rdata1 = d1; rf_rdata2 = d2;
  endtask

  task automatic set_wb(input logic v, input logic [AW-1:0] rd,
                        input logic [XLEN-1:0] d);
    wb_valid = v; wb_rd = rd; wb_data = d;
  endtask

  // One clock: compare against the model at the falling edge, advance the
  // model, then return just after the rising edge.
  task automatic step();
    logic            byp1, byp2, haz, rdy, acc;
    logic [XLEN-1:0] a, b;
    logic [EW-1:0]   e;
    @(negedge clk);
    check("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
    if (m_ov) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL model_queue: empty while output expected valid");
      end else begin
        e = exp_q[0];
        check("out_a", out_a, e[XLEN-1:0]);
        check("out_b", out_b, e[2*XLEN-1:XLEN]);
        check("out_rd", {27'b0, out_rd}, {27'b0, e[2*XLEN+AW-1:2*XLEN]});
        check("out_rd_wen", {31'b0, out_rd_wen}, {31'b0, e[EW-1]});
      end
    end
    if (!rst_n) begin
      check("in_ready_rst", {31'b0, in_ready}, 32'd0);
      m_ov = 0;
      foreach (m_pend[i]) m_pend[i] = 0;
      exp_q.delete();
    end else begin
      check("rf_raddr1", {27'b0, rf_raddr1}, {27'b0, in_rs1});
      check("rf_raddr2", {27'b0, rf_raddr2}, {27'b0, in_rs2});
      byp1 = wb_valid && wb_rd == in_rs1 && in_rs1 != 0;
      byp2 = wb_valid && wb_rd == in_rs2 && in_rs2 != 0;
      a = (in_rs1 == 0) ? '0 : byp1 ? wb_data : rf_rdata1;
      b = (in_rs2 == 0) ? '0 : byp2 ? wb_data : rf_rdata2;
      haz = (in_rs1_used && m_pend[in_rs1] && !byp1)
         || (in_rs2_used && m_pend[in_rs2] && !byp2)
         || (in_rd_wen && in_rd != 0 && m_pend[in_rd]
             && !(wb_valid && wb_rd == in_rd));
      rdy = !haz && !flush && (!m_ov || out_ready);
      check("in_ready", {31'b0, in_ready}, {31'b0, rdy});
      acc = in_valid && rdy;
      if (wb_valid) m_pend[wb_rd] = 0;
      if (m_ov && (flush || out_ready)) begin
        e = exp_q.pop_front();
        if (flush && e[EW-1]) m_pend[e[2*XLEN+AW-1:2*XLEN]] = 0;
      end
      if (acc) begin
        if (in_rd_wen && in_rd != 0) m_pend[in_rd] = 1;
        exp_q.push_back({in_rd_wen, in_rd, b, a});
        m_ov = 1;
      end else if (flush || out_ready) begin
        m_ov = 0;
      end
      m_pend[0] = 0;
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [AW-1:0]   rs1, rs2;
    logic [XLEN-1:0] d1, d2;
    logic            wbv;
    logic [AW-1:0]   wbrd;
    logic [XLEN-1:0] wbd;
    logic [XLEN-1:0] ea, eb;
  } vec_t;

  vec_t vecs [6];

  initial begin
    idle_inputs();
    out_ready = 1;
    m_ov = 0;
    foreach (m_pend[i]) m_pend[i] = 0;

    // reset held for two cycles
    rst_n = 0;
    step(); step();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_a", out_a, 32'd0);
    rst_n = 1;

    // after reset nothing is pending: every register readable at once
    for (int r = 1; r < 32; r += 5) begin
      drive(r[4:0], 1, r[4:0] + 5'd1, 1, 0, 0, 32'h1000 + r, 32'h2000 + r);
      #1 check("rst_no_pend", {31'b0, in_ready}, 32'd1);
      step();
    end

    // table of single instructions with no hazards, back-to-back
    vecs[0] = '{5'd3,  5'd0,  32'd5,        32'd77,       0, 5'd0,  32'd0,     32'd5,        32'd0};
    vecs[1] = '{5'd1,  5'd2,  32'd11,       32'd22,       1, 5'd2,  32'h99,    32'd11,       32'h99};
    vecs[2] = '{5'd9,  5'd9,  32'h123,      32'h456,      1, 5'd9,  32'hCAFE,  32'hCAFE,     32'hCAFE};
    vecs[3] = '{5'd0,  5'd31, 32'hFFFF,     32'h31,       1, 5'd0,  32'd9,     32'd0,        32'h31};
    vecs[4] = '{5'd31, 5'd30, 32'hDEADBEEF, 32'd1,        0, 5'd31, 32'd5,     32'hDEADBEEF, 32'd1};
    vecs[5] = '{5'd15, 5'd16, 32'd0,        32'hFFFFFFFF, 1, 5'd17, 32'd3,     32'd0,        32'hFFFFFFFF};
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].rs1, 1, vecs[i].rs2, 1, 0, 0, vecs[i].d1, vecs[i].d2);
      set_wb(vecs[i].wbv, vecs[i].wbrd, vecs[i].wbd);
      step();
      check($sformatf("vec%0d_a", i), out_a, vecs[i].ea);
      check($sformatf("vec%0d_b", i), out_b, vecs[i].eb);
      check($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'd1);
    end
    idle_inputs();

    // RAW: rd=4 in flight, reader of x4 waits for write-back and bypasses it
    drive(0, 0, 0, 0, 5'd4, 1, 0, 0); step();
    drive(5'd4, 1, 0, 0, 0, 0, 32'h11, 0);
    #1 check("raw_stall", {31'b0, in_ready}, 32'd0);
    step(); step();
    set_wb(1, 5'd4, 32'hAA);
    #1 check("raw_wb_ready", {31'b0, in_ready}, 32'd1);
    step();
    check("raw_bypass_a", out_a, 32'hAA);
    idle_inputs(); step();

    // WAW: second writer of x7 waits; on write-back it issues and x7 stays busy
    drive(0, 0, 0, 0, 5'd7, 1, 0, 0); step();
    drive(0, 0, 0, 0, 5'd7, 1, 0, 0);
    #1 check("waw_stall", {31'b0, in_ready}, 32'd0);
    step();
    set_wb(1, 5'd7, 32'h7);
    #1 check("waw_wb_ready", {31'b0, in_ready}, 32'd1);
    step();
    set_wb(0, 0, 0);
    drive(5'd7, 1, 0, 0, 0, 0, 32'h70, 0);
    #1 check("waw_set_wins", {31'b0, in_ready}, 32'd0);
    step();
    set_wb(1, 5'd7, 32'h77); step();
    idle_inputs(); step();

    // x0 is never bypassed and never pending
    drive(5'd0, 1, 5'd0, 1, 0, 0, 32'hFFFF, 32'hFFFF);
    set_wb(1, 5'd0, 32'd9);
    #1 check("x0_ready", {31'b0, in_ready}, 32'd1);
    step();
    check("x0_out_a", out_a, 32'd0);
    set_wb(0, 0, 0);
    drive(0, 0, 0, 0, 5'd0, 1, 0, 0); step();
    drive(5'd0, 1, 0, 0, 5'd0, 1, 0, 0);
    #1 check("x0_no_pend", {31'b0, in_ready}, 32'd1);
    step();
    idle_inputs(); step();

    // backpressure: output held for three cycles, then one accept per cycle
    drive(5'd2, 1, 0, 0, 0, 0, 32'h22, 0); step();
    out_ready = 0;
    drive(5'd3, 1, 0, 0, 0, 0, 32'h33, 0);
    for (int k = 0; k < 3; k++) begin
      #1 check("bp_not_ready", {31'b0, in_ready}, 32'd0);
      step();
      check("bp_hold_a", out_a, 32'h22);
    end
    out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      drive(5'(k + 1), 1, 0, 0, 0, 0, 32'h100 + k, 0);
      #1 check("bp_b2b_ready", {31'b0, in_ready}, 32'd1);
      step();
      check("bp_b2b_a", out_a, 32'h100 + k);
    end
    idle_inputs(); step();

    // flush kills rd=6 in the output stage and releases its pending bit
    out_ready = 0;
    drive(0, 0, 0, 0, 5'd6, 1, 0, 0); step();
    flush = 1;
    drive(5'd6, 1, 0, 0, 0, 0, 32'h66, 0);
    #1 check("flush_not_ready", {31'b0, in_ready}, 32'd0);
    step();
    flush = 0;
    check("flush_out_valid", {31'b0, out_valid}, 32'd0);
    #1 check("flush_pend_clear", {31'b0, in_ready}, 32'd1);
    step();
    check("flush_reissue_a", out_a, 32'h66);
    out_ready = 1;
    idle_inputs(); step();

    // randomized traffic on a small register window to provoke hazards
    for (int c = 0; c < 600; c++) begin
      in_valid    = ($urandom_range(0, 9) < 8);
      in_rs1      = 5'($urandom_range(0, 7));
      in_rs2      = 5'($urandom_range(0, 7));
      in_rs1_used = $urandom_range(0, 3) != 0;
      in_rs2_used = $urandom_range(0, 1) != 0;
      in_rd       = 5'($urandom_range(0, 7));
      in_rd_wen   = $urandom_range(0, 1) != 0;
      rf_rdata1   = $urandom;
      rf_rdata2   = $urandom;
      wb_valid    = ($urandom_range(0, 9) < 4);
      wb_rd       = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      flush       = ($urandom_range(0, 19) == 0);
      out_ready   = ($urandom_range(0, 9) < 7);
      step();
    end

    // reset dominates a simultaneous flush and clears pending state
    idle_inputs();
    out_ready = 0;
    drive(0, 0, 0, 0, 5'd5, 1, 0, 0); step();
    rst_n = 0; flush = 1;
    step();
    rst_n = 1; flush = 0;
    check("rst_flush_valid", {31'b0, out_valid}, 32'd0);
    drive(5'd5, 1, 0, 0, 0, 0, 32'h55, 0);
    #1 check("rst_pend_clear", {31'b0, in_ready}, 32'd1);
    step();
    out_ready = 1;
    idle_inputs(); step(); step();

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
